// File: rtl/ty_stream_pkg.sv
// Shared types and default sizing for the kernel result stream path.
package ty_stream_pkg;

  localparam int unsigned TY_GVECT      = 2;
  localparam int unsigned TY_DATA_WIDTH = 32 * TY_GVECT;
  localparam int unsigned TY_LEN_WIDTH  = 32;
  localparam int unsigned TY_FIFO_DEPTH = 4;
  localparam int unsigned TY_STALL_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } framer_state_t;

  typedef logic [TY_DATA_WIDTH-1:0] data_word_t;

endpackage

// File: rtl/axis_out_framer_if.sv
// Stream bundle for axis_out_framer: kernel-side input and AXI4-Stream output.
// slave is the framer's view; master is the view of the surrounding kernel/sink.
interface axis_out_framer_if
  import ty_stream_pkg::*;
#(
  parameter int unsigned DATA_W = TY_DATA_WIDTH
);

  logic              s_tvalid;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tready;
  logic              m_tvalid;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;
  logic              m_tready;

  modport slave (
    input  s_tvalid, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast
  );

  modport master (
    output s_tvalid, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast
  );

endinterface

// File: rtl/ty_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered full/empty flags.
module ty_sync_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              do_push;
  logic              do_pop;

  // A push while full is legal only when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full    <= (count_d == CW'(DEPTH));
      empty   <= (count_d == '0);
    end
  end

  // Storage is not reset; contents are only observable behind empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];

endmodule

// File: rtl/axis_out_framer.sv
// Buffers the kernel result stream and re-emits it as AXI4-Stream with tlast on the final word.
// Optional stall counter output enabled by defining TY_OUT_STALL_CNT_EN.
module axis_out_framer
  import ty_stream_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = TY_DATA_WIDTH,
  parameter int unsigned C_LEN_WIDTH  = TY_LEN_WIDTH,
  parameter int unsigned C_FIFO_DEPTH = TY_FIFO_DEPTH
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  input  logic                   start,
  input  logic [C_LEN_WIDTH-1:0] num_words,
  axis_out_framer_if.slave       axis,
  output logic                   busy,
  output logic                   done
`ifdef TY_OUT_STALL_CNT_EN
  ,
  output logic [TY_STALL_W-1:0]  stall_cycles
`endif
);

  framer_state_t state_q;
  framer_state_t state_d;

  logic [C_LEN_WIDTH-1:0]  len_q;
  logic [C_LEN_WIDTH-1:0]  in_cnt_q;
  logic [C_LEN_WIDTH-1:0]  out_cnt_q;
  logic [C_DATA_WIDTH-1:0] fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    start_acc;
  logic                    in_room;
  logic                    s_ready;
  logic                    m_valid;
  logic                    push;
  logic                    pop;
  logic                    last_word;

  // Handshake qualifiers depend only on registered state, never on the peers' valid/ready.
  always_comb begin
    start_acc = (state_q == IDLE) && start;
    in_room   = (in_cnt_q < len_q);
    s_ready   = (state_q == RUN) && !fifo_full && in_room;
    m_valid   = (state_q == RUN) && !fifo_empty;
    push      = axis.s_tvalid && s_ready;
    pop       = m_valid && axis.m_tready;
    last_word = (out_cnt_q == (len_q - C_LEN_WIDTH'(1)));
  end

  assign axis.s_tready = s_ready;
  assign axis.m_tvalid = m_valid;
  assign axis.m_tlast  = m_valid && last_word;
  assign axis.m_tdata  = m_valid ? fifo_rdata : '0;

  ty_sync_fifo #(
    .DATA_W (C_DATA_WIDTH),
    .DEPTH  (C_FIFO_DEPTH)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (areset_n),
    .push  (push),
    .wdata (axis.s_tdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // A zero-length request skips RUN and reports completion straight away.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (num_words == '0) ? FIN : RUN;
      end
      RUN: begin
        if (pop && last_word) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with RUN/FIN.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d == RUN);
      done <= (state_d == FIN);
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else if (start_acc) begin
      len_q     <= num_words;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (push) in_cnt_q  <= in_cnt_q + C_LEN_WIDTH'(1);
      if (pop)  out_cnt_q <= out_cnt_q + C_LEN_WIDTH'(1);
    end
  end

`ifdef TY_OUT_STALL_CNT_EN
  // Counts RUN cycles where a word is offered but the sink holds off; saturating.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      stall_cycles <= '0;
    end else if (start_acc) begin
      stall_cycles <= '0;
    end else if (m_valid && !axis.m_tready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + TY_STALL_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_axis_out_framer.sv
// Directed bench for axis_out_framer; stall counter checks enabled with TY_OUT_STALL_CNT_EN.
module tb_axis_out_framer;

  logic        clk;
  logic        areset_n;
  logic        start;
  logic [31:0] num_words;
  logic        busy;
  logic        done;
`ifdef TY_OUT_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int total = 0;
  int bad   = 0;
  int tnum  = 0;

  axis_out_framer_if #(.DATA_W(64)) bus ();

  axis_out_framer dut (
    .aclk      (clk),
    .areset_n  (areset_n),
    .start     (start),
    .num_words (num_words),
    .axis      (bus),
    .busy      (busy),
    .done      (done)
`ifdef TY_OUT_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s test=%0d got=%h exp=%h", tag, tnum, got, exp);
    end
  endtask

  function automatic logic [63:0] word(input int i);
    return {16'hC0DE, 16'(tnum), 32'(i)};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_tready"}, 64'(bus.s_tready), 64'd0);
    chk({tag, "_m_tvalid"}, 64'(bus.m_tvalid), 64'd0);
    chk({tag, "_m_tlast"},  64'(bus.m_tlast),  64'd0);
    chk({tag, "_m_tdata"},  bus.m_tdata,       64'd0);
    chk({tag, "_busy"},     64'(busy),         64'd0);
    chk({tag, "_done"},     64'(done),         64'd0);
  endtask

  // One transfer of n words against a cycle-level expectation model.
  // Sink stalls for cycles [st0, st0+stn); restart_at re-pulses start; abort_at stops early.
  task automatic xfer(input int n, input int st0, input int stn,
                      input int restart_at, input int abort_at);
    int in_idx, out_idx, occ, last_pop, dones;
    bit finished;
    logic exp_busy, exp_sr, exp_mv, hs_in, hs_out;
    in_idx = 0; out_idx = 0; occ = 0; dones = 0; finished = 0;
    last_pop = (n == 0) ? -1 : -10;
    @(negedge clk);
    start = 1'b1; num_words = 32'(n); bus.s_tvalid = 1'b1; bus.m_tready = 1'b1;
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(negedge clk);
      start        = (cyc == restart_at);
      num_words    = (cyc == restart_at) ? 32'd7 : 32'(n);
      bus.m_tready = !(cyc >= st0 && cyc < st0 + stn);
      bus.s_tdata  = word(in_idx);
      #1;
      if (abort_at >= 0 && out_idx == abort_at) begin
        finished = 1;
        break;
      end
      exp_busy = (n > 0) && (out_idx < n);
      exp_sr   = exp_busy && (occ < 4) && (in_idx < n);
      exp_mv   = exp_busy && (occ > 0);
      chk("busy",     64'(busy),         64'(exp_busy));
      chk("s_tready", 64'(bus.s_tready), 64'(exp_sr));
      chk("m_tvalid", 64'(bus.m_tvalid), 64'(exp_mv));
      chk("m_tlast",  64'(bus.m_tlast),  64'(exp_mv && (out_idx == n - 1)));
      if (exp_mv) chk("m_tdata", bus.m_tdata, word(out_idx));
      chk("done",     64'(done),         64'(cyc == last_pop + 1));
      dones += int'(done);
      hs_in  = exp_sr && bus.s_tvalid;
      hs_out = exp_mv && bus.m_tready;
      if (hs_out) begin
        out_idx++;
        if (out_idx == n) last_pop = cyc;
      end
      if (hs_in) in_idx++;
      occ += int'(hs_in) - int'(hs_out);
      if (out_idx == n && cyc == last_pop + 2) begin
        finished = 1;
        break;
      end
    end
    start = 1'b0;
    bus.s_tvalid = 1'b0;
    chk("xfer_finished", 64'(finished), 64'd1);
    if (abort_at < 0) begin
      chk("words_out", 64'(out_idx), 64'(n));
      chk("done_count", 64'(dones), 64'd1);
    end
  endtask

  initial begin
    areset_n = 1'b0; start = 1'b0; num_words = '0;
    bus.s_tvalid = 1'b0; bus.s_tdata = '0; bus.m_tready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    areset_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    tnum = 1; xfer(8, 0, 0, -1, -1);     // full-rate streaming
    tnum = 2; xfer(5, 0, 10, -1, -1);    // sink stall fills the buffer
    tnum = 3; xfer(0, 0, 0, -1, -1);     // zero-length request
    tnum = 4; xfer(1, 0, 0, 0, -1);      // single word, extra start ignored

    tnum = 5; xfer(6, 0, 0, -1, 3);      // reset after 3 of 6 words
    areset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midreset_no_done", 64'(done), 64'd0);
    end
    areset_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");
    tnum = 6; xfer(2, 0, 0, -1, -1);

    tnum = 7; xfer(4, 1, 7, -1, -1);     // 7 stalled cycles with a word offered
`ifdef TY_OUT_STALL_CNT_EN
    chk("stall_cycles", 64'(stall_cycles), 64'd7);
    @(negedge clk);
    chk("stall_hold", 64'(stall_cycles), 64'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
